// File: rtl/core_wb.sv
// core_wb: writeback stage of the TOY core.
// Two small result FIFOs (EX, MEM) feed a round-robin arbiter that drives a
// registered register-file write port. pend_o flags every register that still
// has a write buffered or on the write port. Writes to R0 are accepted and
// dropped at the FIFO input because R0 is hardwired zero.

// Per-channel result FIFO with registered ready and a pending-register bitmap.
module core_wb_fifo #(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        arst_i,
   input  logic        push_i,
   input  logic [3:0]  addr_i,
   input  logic [15:0] data_i,
   input  logic        pop_i,
   output logic        ready_o,
   output logic        head_valid_o,
   output logic [3:0]  head_addr_o,
   output logic [15:0] head_data_o,
   output logic [15:0] pend_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [19:0]   mem_q [DEPTH];
   logic [19:0]   mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ready_q, ready_d;
   logic [PW-1:0] offset;

   // Next-state for storage, pointers, occupancy and the registered ready flag.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         mem_d[wr_ptr_q] = {addr_i, data_i};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // Ready reflects occupancy after this edge, so a full FIFO that pops
      // only reopens after the edge (no same-edge push-when-full).
      ready_d = (count_d < FULL);
   end

   // FIFO state registers; reset empties the FIFO and drops ready.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 20'h00000;
         end
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
         ready_q  <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
      end
   end

   // Bitmap of destination registers held in the occupied slots.
   always_comb begin
      pend_o = 16'h0000;
      offset = {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         offset = PW'(i) - rd_ptr_q;
         if ({1'b0, offset} < count_q) begin
            pend_o[mem_q[i][19:16]] = 1'b1;
         end else begin
            pend_o = pend_o;
         end
      end
   end

   assign ready_o      = ready_q;
   assign head_valid_o = (count_q != {CW{1'b0}});
   assign head_addr_o  = mem_q[rd_ptr_q][19:16];
   assign head_data_o  = mem_q[rd_ptr_q][15:0];
endmodule

// Writeback top: two channel FIFOs, round-robin arbiter, registered write port.
module core_wb #(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        arst_i,
   input  logic        ex_valid_i,
   output logic        ex_ready_o,
   input  logic [3:0]  ex_addr_i,
   input  logic [15:0] ex_data_i,
   input  logic        mem_valid_i,
   output logic        mem_ready_o,
   input  logic [3:0]  mem_addr_i,
   input  logic [15:0] mem_data_i,
   output logic        w_en_o,
   output logic [3:0]  w_addr_o,
   output logic [15:0] w_data_o,
   output logic [15:0] pend_o
);
   typedef enum logic {
      RR_EX  = 1'b0,
      RR_MEM = 1'b1
   } rr_e;

   rr_e         rr_q, rr_d;
   logic        w_en_q, w_en_d;
   logic [3:0]  w_addr_q, w_addr_d;
   logic [15:0] w_data_q, w_data_d;

   logic        ex_push, mem_push;
   logic        grant_ex, grant_mem;
   logic        ex_head_valid, mem_head_valid;
   logic [3:0]  ex_head_addr, mem_head_addr;
   logic [15:0] ex_head_data, mem_head_data;
   logic [15:0] ex_pend, mem_pend, wport_pend;

   // R0 beats complete the handshake but never occupy a slot.
   assign ex_push  = ex_valid_i  & ex_ready_o  & (ex_addr_i  != 4'd0);
   assign mem_push = mem_valid_i & mem_ready_o & (mem_addr_i != 4'd0);

   core_wb_fifo #(.DEPTH(DEPTH)) u_ex_fifo (
      .clk_i        (clk_i),
      .arst_i       (arst_i),
      .push_i       (ex_push),
      .addr_i       (ex_addr_i),
      .data_i       (ex_data_i),
      .pop_i        (grant_ex),
      .ready_o      (ex_ready_o),
      .head_valid_o (ex_head_valid),
      .head_addr_o  (ex_head_addr),
      .head_data_o  (ex_head_data),
      .pend_o       (ex_pend)
   );

   core_wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
      .clk_i        (clk_i),
      .arst_i       (arst_i),
      .push_i       (mem_push),
      .addr_i       (mem_addr_i),
      .data_i       (mem_data_i),
      .pop_i        (grant_mem),
      .ready_o      (mem_ready_o),
      .head_valid_o (mem_head_valid),
      .head_addr_o  (mem_head_addr),
      .head_data_o  (mem_head_data),
      .pend_o       (mem_pend)
   );

   // Arbitration: lone requester wins; on contention the pointer picks and flips.
   always_comb begin
      grant_ex  = 1'b0;
      grant_mem = 1'b0;
      rr_d      = rr_q;
      if (ex_head_valid && mem_head_valid) begin
         case (rr_q)
            RR_EX: begin
               grant_ex = 1'b1;
               rr_d     = RR_MEM;
            end
            RR_MEM: begin
               grant_mem = 1'b1;
               rr_d      = RR_EX;
            end
            default: begin
               grant_ex = 1'b1;
               rr_d     = RR_MEM;
            end
         endcase
      end else if (ex_head_valid) begin
         grant_ex = 1'b1;
      end else if (mem_head_valid) begin
         grant_mem = 1'b1;
      end else begin
         rr_d = rr_q;
      end
   end

   // Write-port next state: load the winning head, otherwise hold address/data.
   always_comb begin
      w_en_d   = grant_ex | grant_mem;
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;
      if (grant_ex) begin
         w_addr_d = ex_head_addr;
         w_data_d = ex_head_data;
      end else if (grant_mem) begin
         w_addr_d = mem_head_addr;
         w_data_d = mem_head_data;
      end else begin
         w_addr_d = w_addr_q;
         w_data_d = w_data_q;
      end
   end

   // Arbiter pointer and write-port registers.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         rr_q     <= RR_EX;
         w_en_q   <= 1'b0;
         w_addr_q <= 4'd0;
         w_data_q <= 16'h0000;
      end else begin
         rr_q     <= rr_d;
         w_en_q   <= w_en_d;
         w_addr_q <= w_addr_d;
         w_data_q <= w_data_d;
      end
   end

   // Pending bitmap: buffered entries plus the write currently on the port.
   always_comb begin
      wport_pend = 16'h0000;
      if (w_en_q) begin
         wport_pend[w_addr_q] = 1'b1;
      end else begin
         wport_pend = 16'h0000;
      end
      pend_o = (ex_pend | mem_pend | wport_pend) & 16'hFFFE;
   end

   assign w_en_o   = w_en_q;
   assign w_addr_o = w_addr_q;
   assign w_data_o = w_data_q;
endmodule

// File: tb/tb_core_wb.sv
// Self-checking bench for core_wb: directed vector table, hand-written
// backpressure and reset sequences, and random traffic against a queue model.
module tb_core_wb;
   localparam int DEPTH = 4;

   logic        clk_i = 1'b0;
   logic        arst_i = 1'b1;
   logic        ex_valid_i = 1'b0;
   logic        ex_ready_o;
   logic [3:0]  ex_addr_i = 4'd0;
   logic [15:0] ex_data_i = 16'h0000;
   logic        mem_valid_i = 1'b0;
   logic        mem_ready_o;
   logic [3:0]  mem_addr_i = 4'd0;
   logic [15:0] mem_data_i = 16'h0000;
   logic        w_en_o;
   logic [3:0]  w_addr_o;
   logic [15:0] w_data_o;
   logic [15:0] pend_o;

   core_wb #(.DEPTH(DEPTH)) dut (
      .clk_i       (clk_i),
      .arst_i      (arst_i),
      .ex_valid_i  (ex_valid_i),
      .ex_ready_o  (ex_ready_o),
      .ex_addr_i   (ex_addr_i),
      .ex_data_i   (ex_data_i),
      .mem_valid_i (mem_valid_i),
      .mem_ready_o (mem_ready_o),
      .mem_addr_i  (mem_addr_i),
      .mem_data_i  (mem_data_i),
      .w_en_o      (w_en_o),
      .w_addr_o    (w_addr_o),
      .w_data_o    (w_data_o),
      .pend_o      (pend_o)
   );

   always #5 clk_i = ~clk_i;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model: queues + round-robin bit ----------------
   logic [19:0] mq_ex[$];
   logic [19:0] mq_mem[$];
   bit          m_rr_mem  = 1'b0;   // 1: MEM is favoured on the next contention
   logic        m_wen     = 1'b0;
   logic [3:0]  m_waddr   = 4'd0;
   logic [15:0] m_wdata   = 16'h0000;
   logic        m_ex_rdy  = 1'b0;
   logic        m_mem_rdy = 1'b0;

   always @(posedge clk_i or posedge arst_i) begin : model
      bit          ex_fire, mem_fire;
      int          win;
      logic [19:0] e;
      if (arst_i) begin
         mq_ex.delete();
         mq_mem.delete();
         m_rr_mem  = 1'b0;
         m_wen     = 1'b0;
         m_waddr   = 4'd0;
         m_wdata   = 16'h0000;
         m_ex_rdy  = 1'b0;
         m_mem_rdy = 1'b0;
      end else begin
         ex_fire  = ex_valid_i  && m_ex_rdy;
         mem_fire = mem_valid_i && m_mem_rdy;
         win = 0;
         if (mq_ex.size() > 0 && mq_mem.size() > 0) begin
            win = m_rr_mem ? 2 : 1;
            m_rr_mem = !m_rr_mem;
         end else if (mq_ex.size() > 0) win = 1;
         else if (mq_mem.size() > 0) win = 2;
         m_wen = (win != 0);
         if (win == 1) begin
            e = mq_ex.pop_front();
            m_waddr = e[19:16];
            m_wdata = e[15:0];
         end else if (win == 2) begin
            e = mq_mem.pop_front();
            m_waddr = e[19:16];
            m_wdata = e[15:0];
         end
         if (ex_fire && ex_addr_i != 4'd0) mq_ex.push_back({ex_addr_i, ex_data_i});
         if (mem_fire && mem_addr_i != 4'd0) mq_mem.push_back({mem_addr_i, mem_data_i});
         m_ex_rdy  = (mq_ex.size() < DEPTH);
         m_mem_rdy = (mq_mem.size() < DEPTH);
      end
   end

   function automatic logic [15:0] model_pend();
      logic [15:0] p = 16'h0000;
      foreach (mq_ex[i])  p[mq_ex[i][19:16]]  = 1'b1;
      foreach (mq_mem[i]) p[mq_mem[i][19:16]] = 1'b1;
      if (m_wen) p[m_waddr] = 1'b1;
      p[0] = 1'b0;
      return p;
   endfunction

   task automatic cmp_model(input string tag);
      chk({tag, " w_en"},      32'(w_en_o),      32'(m_wen));
      chk({tag, " w_addr"},    32'(w_addr_o),    32'(m_waddr));
      chk({tag, " w_data"},    32'(w_data_o),    32'(m_wdata));
      chk({tag, " pend"},      32'(pend_o),      32'(model_pend()));
      chk({tag, " ex_ready"},  32'(ex_ready_o),  32'(m_ex_rdy));
      chk({tag, " mem_ready"}, 32'(mem_ready_o), 32'(m_mem_rdy));
   endtask

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic idle_inputs();
      ex_valid_i  = 1'b0;
      mem_valid_i = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic ev; logic [3:0] ea; logic [15:0] ed;
      logic mv; logic [3:0] ma; logic [15:0] md;
      logic wen; logic [3:0] wa; logic [15:0] wd; logic [15:0] pend;
      logic erdy; logic mrdy;
   } vec_t;

   vec_t vt[15];

   logic [3:0] push_list[$];
   logic [3:0] got_list[$];

   initial begin
      bit   full_seen;
      bit   first_pop_seen;
      logic prev_rdy;
      int   rate_ex, rate_mem;

      // Each row: inputs driven before one edge, outputs expected after it.
      vt[0]  = '{1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0020, 1'b1, 1'b1};
      vt[1]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 16'hBEEF, 16'h0020, 1'b1, 1'b1};
      vt[2]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd5, 16'hBEEF, 16'h0000, 1'b1, 1'b1};
      vt[3]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'h1234, 1'b0, 4'd5, 16'hBEEF, 16'h0000, 1'b1, 1'b1};
      vt[4]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd5, 16'hBEEF, 16'h0000, 1'b1, 1'b1};
      vt[5]  = '{1'b1, 4'd6, 16'h0606, 1'b1, 4'd7, 16'h0707, 1'b0, 4'd5, 16'hBEEF, 16'h00C0, 1'b1, 1'b1};
      vt[6]  = '{1'b1, 4'd6, 16'h1606, 1'b1, 4'd7, 16'h1707, 1'b1, 4'd6, 16'h0606, 16'h00C0, 1'b1, 1'b1};
      vt[7]  = '{1'b1, 4'd6, 16'h2606, 1'b1, 4'd7, 16'h2707, 1'b1, 4'd7, 16'h0707, 16'h00C0, 1'b1, 1'b1};
      vt[8]  = '{1'b1, 4'd6, 16'h3606, 1'b1, 4'd7, 16'h3707, 1'b1, 4'd6, 16'h1606, 16'h00C0, 1'b1, 1'b1};
      vt[9]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 16'h1707, 16'h00C0, 1'b1, 1'b1};
      vt[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd6, 16'h2606, 16'h00C0, 1'b1, 1'b1};
      vt[11] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 16'h2707, 16'h00C0, 1'b1, 1'b1};
      vt[12] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd6, 16'h3606, 16'h00C0, 1'b1, 1'b1};
      vt[13] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 16'h3707, 16'h0080, 1'b1, 1'b1};
      vt[14] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd7, 16'h3707, 16'h0000, 1'b1, 1'b1};

      // ---- reset held with random inputs: everything reads zero ----
      for (int c = 0; c < 4; c++) begin
         ex_valid_i  = 1'($urandom_range(0, 1));
         ex_addr_i   = 4'($urandom_range(0, 15));
         ex_data_i   = 16'($urandom);
         mem_valid_i = 1'($urandom_range(0, 1));
         mem_addr_i  = 4'($urandom_range(0, 15));
         mem_data_i  = 16'($urandom);
         tick();
         chk("rst w_en",      32'(w_en_o),      32'd0);
         chk("rst w_addr",    32'(w_addr_o),    32'd0);
         chk("rst w_data",    32'(w_data_o),    32'd0);
         chk("rst pend",      32'(pend_o),      32'd0);
         chk("rst ex_ready",  32'(ex_ready_o),  32'd0);
         chk("rst mem_ready", 32'(mem_ready_o), 32'd0);
      end
      idle_inputs();
      arst_i = 1'b0;
      #1;
      chk("rel ex_ready before edge", 32'(ex_ready_o), 32'd0);
      tick();
      chk("rel ex_ready",  32'(ex_ready_o),  32'd1);
      chk("rel mem_ready", 32'(mem_ready_o), 32'd1);

      // ---- vector table: single write, R0 drop, round-robin alternation ----
      for (int i = 0; i < 15; i++) begin
         ex_valid_i  = vt[i].ev;  ex_addr_i  = vt[i].ea; ex_data_i  = vt[i].ed;
         mem_valid_i = vt[i].mv;  mem_addr_i = vt[i].ma; mem_data_i = vt[i].md;
         tick();
         chk($sformatf("row%0d w_en", i),      32'(w_en_o),      32'(vt[i].wen));
         chk($sformatf("row%0d w_addr", i),    32'(w_addr_o),    32'(vt[i].wa));
         chk($sformatf("row%0d w_data", i),    32'(w_data_o),    32'(vt[i].wd));
         chk($sformatf("row%0d pend", i),      32'(pend_o),      32'(vt[i].pend));
         chk($sformatf("row%0d ex_ready", i),  32'(ex_ready_o),  32'(vt[i].erdy));
         chk($sformatf("row%0d mem_ready", i), 32'(mem_ready_o), 32'(vt[i].mrdy));
      end

      // ---- fill EX under competing MEM traffic until backpressure ----
      full_seen   = 1'b0;
      ex_valid_i  = 1'b1; ex_addr_i  = 4'd1; ex_data_i  = 16'hE001;
      mem_valid_i = 1'b1; mem_addr_i = 4'd15; mem_data_i = 16'hA000;
      for (int c = 0; c < 60 && !full_seen; c++) begin
         bit ex_fire, mem_fire;
         ex_fire  = ex_valid_i  && ex_ready_o;
         mem_fire = mem_valid_i && mem_ready_o;
         tick();
         cmp_model("fill");
         if (w_en_o && w_addr_o != 4'd15) got_list.push_back(w_addr_o);
         if (ex_fire) begin
            push_list.push_back(ex_addr_i);
            ex_addr_i = (ex_addr_i == 4'd14) ? 4'd1 : ex_addr_i + 4'd1;
            ex_data_i = ex_data_i + 16'd1;
         end
         if (mem_fire) mem_data_i = mem_data_i + 16'd1;
         if (!ex_ready_o) full_seen = 1'b1;
      end
      chk("ex backpressure reached", 32'(full_seen), 32'd1);

      // ---- drain: EX order preserved, ready reopens right after first pop ----
      ex_valid_i = 1'b0;
      first_pop_seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         bit mem_fire;
         if (c == 6) mem_valid_i = 1'b0;
         mem_fire = mem_valid_i && mem_ready_o;
         prev_rdy = ex_ready_o;
         tick();
         cmp_model("drain");
         if (mem_fire) mem_data_i = mem_data_i + 16'd1;
         if (w_en_o && w_addr_o != 4'd15) begin
            got_list.push_back(w_addr_o);
            if (!first_pop_seen) begin
               first_pop_seen = 1'b1;
               chk("ex_ready low before first pop", 32'(prev_rdy),   32'd0);
               chk("ex_ready high after first pop", 32'(ex_ready_o), 32'd1);
            end
         end
      end
      chk("ex pop seen", 32'(first_pop_seen), 32'd1);
      chk("ex write count", 32'(got_list.size()), 32'(push_list.size()));
      for (int i = 0; i < push_list.size() && i < got_list.size(); i++)
         chk($sformatf("ex order %0d", i), 32'(got_list[i]), 32'(push_list[i]));

      // ---- reset in the middle of traffic ----
      ex_valid_i  = 1'b1; ex_addr_i  = 4'd10; ex_data_i  = 16'h0A0A;
      mem_valid_i = 1'b1; mem_addr_i = 4'd13; mem_data_i = 16'h0D0D;
      tick();
      ex_addr_i  = 4'd11; ex_data_i  = 16'h0B0B;
      mem_addr_i = 4'd14; mem_data_i = 16'h0E0E;
      tick();
      cmp_model("pre-reset");
      chk("pre-reset w_en", 32'(w_en_o), 32'd1);
      idle_inputs();
      #2 arst_i = 1'b1;
      #1;
      chk("mid-reset w_en",      32'(w_en_o),      32'd0);
      chk("mid-reset pend",      32'(pend_o),      32'd0);
      chk("mid-reset ex_ready",  32'(ex_ready_o),  32'd0);
      chk("mid-reset mem_ready", 32'(mem_ready_o), 32'd0);
      @(negedge clk_i);
      arst_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("post-reset w_en %0d", c), 32'(w_en_o), 32'd0);
         chk($sformatf("post-reset pend %0d", c), 32'(pend_o), 32'd0);
         cmp_model("post-reset");
      end

      // ---- random traffic against the model, with occasional async resets ----
      rate_ex = 60; rate_mem = 60;
      for (int c = 0; c < 1200; c++) begin
         if (c % 100 == 0) begin
            rate_ex  = $urandom_range(10, 100);
            rate_mem = $urandom_range(10, 100);
         end
         if (!(ex_valid_i && !ex_ready_o)) begin
            ex_valid_i = ($urandom_range(0, 99) < rate_ex);
            ex_addr_i  = 4'($urandom_range(0, 15));
            ex_data_i  = 16'($urandom);
         end
         if (!(mem_valid_i && !mem_ready_o)) begin
            mem_valid_i = ($urandom_range(0, 99) < rate_mem);
            mem_addr_i  = 4'($urandom_range(0, 15));
            mem_data_i  = 16'($urandom);
         end
         tick();
         cmp_model("rand");
         if (c % 300 == 299) begin
            #2 arst_i = 1'b1;
            #1;
            cmp_model("rand-reset");
            @(negedge clk_i);
            arst_i = 1'b0;
            idle_inputs();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
